// File: rtl/ext_pkg.sv
// ext_pkg -- shared definitions for the immediate-extension pipeline.
//
// Holds the EOp mode encodings used by the decoder and the bench, and the
// occupancy states of the two-entry output buffer in ext_pipe.
// No ports (package).

package ext_pkg;

    // Extension mode encodings (EOp). 3'b101..3'b111 are reserved.
    localparam logic [2:0] EXT_SIGN    = 3'b000;
    localparam logic [2:0] EXT_ZERO    = 3'b001;
    localparam logic [2:0] EXT_HIGH    = 3'b010;
    localparam logic [2:0] EXT_SIGN_SH = 3'b011;
    localparam logic [2:0] EXT_ZERO_SH = 3'b100;

    // Occupancy of the in-order result buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/ext_comb.sv
// ext_comb -- purely combinational immediate extender.
//
// Ports:
//   imm     (in,  IMM_W)  immediate operand
//   eop     (in,  3)      extension mode, encodings from ext_pkg
//   ext     (out, DATA_W) extended result (0 for reserved modes)
//   ext_err (out, 1)      set when eop is a reserved encoding
//
// Parameters: IMM_W, DATA_W, SHAMT. DATA_W must be at least IMM_W + SHAMT
// so the shifted modes never lose immediate bits.

module ext_comb
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHAMT  = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        eop,
    output logic [DATA_W-1:0] ext,
    output logic              ext_err
);

    logic [DATA_W-1:0] sx;
    logic [DATA_W-1:0] zx;

    // Size casts of a signed/unsigned operand give sign/zero extension and
    // stay legal even when DATA_W == IMM_W (no zero-width replication).
    assign sx = DATA_W'($signed(imm));
    assign zx = DATA_W'(imm);

    always_comb begin
        ext     = '0;
        ext_err = 1'b0;
        case (eop)
            EXT_SIGN:    ext = sx;
            EXT_ZERO:    ext = zx;
            EXT_HIGH:    ext = zx << (DATA_W - IMM_W);
            EXT_SIGN_SH: ext = sx << SHAMT;
            EXT_ZERO_SH: ext = zx << SHAMT;
            default:     ext_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe -- valid/ready wrapper around ext_comb with a 2-entry result buffer.
//
// Ports:
//   clk       (in,  1)      rising-edge clock
//   reset     (in,  1)      synchronous active-high reset
//   in_valid  (in,  1)      request valid
//   in_ready  (out, 1)      request accepted this cycle (registered)
//   imm       (in,  IMM_W)  immediate operand
//   EOp       (in,  3)      extension mode
//   out_valid (out, 1)      result valid (registered)
//   out_ready (in,  1)      consumer accepts result
//   ext       (out, DATA_W) extended result (registered)
//   ext_err   (out, 1)      result came from a reserved EOp (registered)
//
// Requests are decoded at the input and the decoded result is stored, so a
// request accepted on one edge is visible at the outputs right after it.
// The head entry drives the outputs directly; the tail entry only fills
// when the consumer stalls, which is what keeps full throughput with a
// registered in_ready.

module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHAMT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        EOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext,
    output logic              ext_err
);

    logic [DATA_W-1:0] dec_ext;
    logic              dec_err;

    ext_comb #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .SHAMT  (SHAMT)
    ) u_dec (
        .imm     (imm),
        .eop     (EOp),
        .ext     (dec_ext),
        .ext_err (dec_err)
    );

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_ext_q, head_ext_d;
    logic              head_err_q, head_err_d;
    logic [DATA_W-1:0] tail_ext_q, tail_ext_d;
    logic              tail_err_q, tail_err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic push;
    logic pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        head_ext_d = head_ext_q;
        head_err_d = head_err_q;
        tail_ext_d = tail_ext_q;
        tail_err_d = tail_err_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_ext_d = dec_ext;
                    head_err_d = dec_err;
                    state_d    = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_ext_d = dec_ext;
                        tail_err_d = dec_err;
                        state_d    = BUF_FULL;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: begin
                        // Head leaves and the new request takes its place.
                        head_ext_d = dec_ext;
                        head_err_d = dec_err;
                    end
                    default: ;
                endcase
            end
            BUF_FULL: begin
                // in_ready is low whenever FULL, so only a pop can occur.
                if (pop) begin
                    head_ext_d = tail_ext_q;
                    head_err_d = tail_err_q;
                    state_d    = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase

        // Flags are derived from the next state so they line up with it.
        in_ready_d  = (state_d != BUF_FULL);
        out_valid_d = (state_d != BUF_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BUF_EMPTY;
            head_ext_q  <= '0;
            head_err_q  <= 1'b0;
            tail_ext_q  <= '0;
            tail_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_ext_q  <= head_ext_d;
            head_err_q  <= head_err_d;
            tail_ext_q  <= tail_ext_d;
            tail_err_q  <= tail_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ext       = head_ext_q;
    assign ext_err   = head_err_q;

endmodule
